// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI mode encodings and master FSM states, shared with the slave
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr_i, wrapping
module spi_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     valid_o
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_master_sched.sv
// rtl/spi_master_sched.sv - SPI master sharing one bus between N_REQ requesters, round-robin granted
module spi_master_sched import spi_pkg::*; #(
  parameter logic [1:0] mode     = MODE0,
  parameter int         bits_num = 8,
  parameter int         N_REQ    = 2,
  parameter int         CLK_DIV  = 4,
  parameter int         SS_GAP   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*bits_num-1:0] req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      done,
  output logic [bits_num-1:0]       rx_data,
  output logic [$clog2(N_REQ)-1:0]  rx_id,
  output logic                      sclk,
  output logic [N_REQ-1:0]          ss_n,
  output logic                      mosi,
  input  logic                      miso,
  output logic                      tx_end
);

  localparam int IW    = $clog2(N_REQ);
  localparam int DW    = $clog2(CLK_DIV);
  localparam int NEDGE = 2 * bits_num;
  localparam int EW    = $clog2(((NEDGE + 1) > SS_GAP) ? (NEDGE + 1) : SS_GAP);
  localparam logic CPOL = mode[CPOL_BIT];
  localparam logic CPHA = mode[CPHA_BIT];
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(NEDGE - 1);
  localparam logic [EW-1:0] GAP_LAST  = EW'(SS_GAP - 1);

  state_e              state_q;
  logic [DW-1:0]       div_q;
  logic [EW-1:0]       edge_q;
  logic [IW-1:0]       rr_q;
  logic [IW-1:0]       id_q;
  logic [bits_num-1:0] tx_q;
  logic [bits_num-1:0] rx_q;
  logic [N_REQ-1:0]    gnt_q;
  logic                busy_q;
  logic                done_q;
  logic [bits_num-1:0] rx_data_q;
  logic [IW-1:0]       rx_id_q;
  logic                sclk_q;
  logic [N_REQ-1:0]    ss_n_q;
  logic                mosi_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;

  spi_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // edge_q counts edges already made, so the upcoming edge is leading when edge_q is even
  logic tick, leading, sample, last_edge;
  assign tick      = (div_q == DIV_LAST);
  assign leading   = ~edge_q[0];
  assign sample    = leading ^ CPHA;
  assign last_edge = (edge_q == EDGE_LAST);

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tx_end  = done_q;
  assign rx_data = rx_data_q;
  assign rx_id   = rx_id_q;
  assign sclk    = sclk_q;
  assign ss_n    = ss_n_q;
  assign mosi    = mosi_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      rr_q      <= '0;
      id_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      rx_id_q   <= '0;
      sclk_q    <= CPOL;
      ss_n_q    <= '1;
      mosi_q    <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          div_q  <= '0;
          edge_q <= '0;
          if (arb_valid) begin
            gnt_q   <= arb_gnt;
            id_q    <= arb_idx;
            tx_q    <= req_data[arb_idx*bits_num +: bits_num];
            rr_q    <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          ss_n_q  <= ~(N_REQ'(1) << id_q);
          mosi_q  <= tx_q[bits_num-1];
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
            if (sample) begin
              rx_q <= {rx_q[bits_num-2:0], miso};
            end else if (CPHA) begin
              mosi_q <= tx_q[bits_num-1];
              tx_q   <= tx_q << 1;
            end else if (!last_edge) begin
              mosi_q <= tx_q[bits_num-2];
              tx_q   <= tx_q << 1;
            end
            if (last_edge) begin
              state_q <= ST_HOLD;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            div_q     <= '0;
            edge_q    <= '0;
            ss_n_q    <= '1;
            done_q    <= 1'b1;
            rx_data_q <= rx_q;
            rx_id_q   <= id_q;
            state_q   <= ST_GAP;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        ST_GAP: begin
          // edge_q is reused here to count idle half-periods
          if (tick) begin
            div_q <= '0;
            if (edge_q == GAP_LAST) begin
              edge_q  <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              edge_q <= edge_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// tb/tb_spi_master_sched.sv - randomized self-checking bench, one master instance per SPI mode
module tb_spi_master_sched;

  localparam int B      = 8;
  localparam int N      = 2;
  localparam int CD     = 4;
  localparam int SG     = 2;
  localparam int EDGES  = 2 * B;
  localparam int T_DONE = 1 + (2 * B + 1) * CD;
  localparam int T_NEXT = T_DONE + SG * CD + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0]   req_v      [4];
  logic [N*B-1:0] req_data_v [4];
  logic [N-1:0]   gnt_v      [4];
  logic           busy_v     [4];
  logic           done_v     [4];
  logic [B-1:0]   rx_data_v  [4];
  logic           rx_id_v    [4];
  logic           sclk_v     [4];
  logic [N-1:0]   ss_n_v     [4];
  logic           mosi_v     [4];
  logic           miso_v     [4];
  logic           tx_end_v   [4];

  // slave-side model state, updated once per clk at the falling edge
  logic           loop_en    [4];
  logic [B-1:0]   slave_word [4][N];
  logic           sbit       [4];
  logic [B-1:0]   cap        [4];
  logic           psclk      [4];
  bit             active     [4];
  int             e_cnt      [4];
  int             sel        [4];
  int             ss_fall    [4];
  int             done_cnt   [4];
  int             ss_err;
  int             rr_model   [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    assign miso_v[m] = loop_en[m] ? mosi_v[m] : sbit[m];
    spi_master_sched #(
      .mode(2'(m)), .bits_num(B), .N_REQ(N), .CLK_DIV(CD), .SS_GAP(SG)
    ) u_dut (
      .clk(clk), .reset(rst_n), .req(req_v[m]), .req_data(req_data_v[m]),
      .gnt(gnt_v[m]), .busy(busy_v[m]), .done(done_v[m]), .rx_data(rx_data_v[m]),
      .rx_id(rx_id_v[m]), .sclk(sclk_v[m]), .ss_n(ss_n_v[m]), .mosi(mosi_v[m]),
      .miso(miso_v[m]), .tx_end(tx_end_v[m])
    );
  end

  // SPI slave behaviour: shifts data_in out MSB first, captures mosi on its sample edges
  initial begin
    ss_err = 0;
    for (int m = 0; m < 4; m++) begin
      sbit[m] = 1'b0; cap[m] = '0; psclk[m] = m[1]; active[m] = 0;
      e_cnt[m] = 0; sel[m] = 0; ss_fall[m] = 0; done_cnt[m] = 0;
    end
    forever begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        int lows;
        int bidx;
        lows = 0;
        for (int i = 0; i < N; i++) if (ss_n_v[m][i] === 1'b0) lows++;
        if (lows > 1) ss_err++;
        if (done_v[m] === 1'b1) done_cnt[m]++;
        if (lows != 0) begin
          if (!active[m]) begin
            active[m] = 1; e_cnt[m] = 0; cap[m] = '0; ss_fall[m] = cyc;
            for (int i = 0; i < N; i++) if (ss_n_v[m][i] === 1'b0) sel[m] = i;
          end
          if (sclk_v[m] !== psclk[m]) begin
            e_cnt[m]++;
            if (((e_cnt[m] % 2) == 1) != ((m % 2) == 1)) cap[m] = {cap[m][B-2:0], mosi_v[m]};
          end
          if ((m % 2) == 1) bidx = (e_cnt[m] > 0) ? (e_cnt[m] - 1) / 2 : 0;
          else bidx = e_cnt[m] / 2;
          sbit[m] = (bidx < B) ? slave_word[m][sel[m]][B-1-bidx] : 1'b0;
        end else begin
          active[m] = 0;
          sbit[m] = 1'b0;
        end
        psclk[m] = sclk_v[m];
      end
    end
  end

  task automatic wait_gnt(input int m);
    int n = 0;
    do begin @(negedge clk); n++; end while (gnt_v[m] === '0 && n < 300);
    if (gnt_v[m] === '0) begin errors++; $display("FAIL gnt_timeout m%0d: no gnt after %0d cycles", m, n); end
  endtask

  task automatic wait_done(input int m);
    int n = 0;
    do begin @(negedge clk); n++; end while (done_v[m] !== 1'b1 && n < 300);
    if (done_v[m] !== 1'b1) begin errors++; $display("FAIL done_timeout m%0d: no done after %0d cycles", m, n); end
  endtask

  task automatic wait_idle(input int m);
    int n = 0;
    while (busy_v[m] !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (busy_v[m] !== 1'b0) begin errors++; $display("FAIL idle_timeout m%0d: busy stuck", m); end
  endtask

  // one transfer on instance m for requester id; reference: fixed latencies and the slave's word
  task automatic run_one(input int m, input int id, input logic [B-1:0] w,
                         input logic [B-1:0] sw, input bit loop);
    int t;
    logic [B-1:0] exp_rx;
    logic [N-1:0] exp_gnt;
    exp_gnt = N'(1) << id;
    exp_rx = loop ? w : sw;
    slave_word[m][id] = sw;
    loop_en[m] = loop;
    req_data_v[m] = (N*B)'($urandom);
    req_data_v[m][id*B +: B] = w;
    req_v[m] = exp_gnt;
    wait_gnt(m);
    t = cyc;
    checks++;
    if (gnt_v[m] !== exp_gnt) begin errors++; $display("FAIL gnt m%0d: got %b want %b", m, gnt_v[m], exp_gnt); end
    req_v[m] = '0;
    req_data_v[m] = (N*B)'($urandom);
    rr_model[m] = (id + 1) % N;
    wait_done(m);
    checks++;
    if (cyc - t != T_DONE) begin errors++; $display("FAIL done_latency m%0d: got %0d want %0d", m, cyc - t, T_DONE); end
    checks++;
    if ({rx_id_v[m], rx_data_v[m]} !== {1'(id), exp_rx}) begin
      errors++; $display("FAIL rx m%0d: got id %0d data %h want id %0d data %h", m, rx_id_v[m], rx_data_v[m], id, exp_rx);
    end
    checks++;
    if (cap[m] !== w || sel[m] != id) begin
      errors++; $display("FAIL slave_rx m%0d: got %h on ss%0d want %h on ss%0d", m, cap[m], sel[m], w, id);
    end
    checks++;
    if (e_cnt[m] != EDGES || ss_fall[m] - t != 1) begin
      errors++; $display("FAIL framing m%0d: got edges %0d ss_fall +%0d want %0d +1", m, e_cnt[m], ss_fall[m] - t, EDGES);
    end
    checks++;
    if ({tx_end_v[m], ss_n_v[m], sclk_v[m]} !== {1'b1, {N{1'b1}}, 1'(m >> 1)}) begin
      errors++; $display("FAIL end_state m%0d: got tx_end %b ss_n %b sclk %b want 1 %b %0d", m, tx_end_v[m], ss_n_v[m], sclk_v[m], {N{1'b1}}, m >> 1);
    end
    wait_idle(m);
    checks++;
    if (cyc - t != T_NEXT - 1) begin errors++; $display("FAIL busy_fall m%0d: got %0d want %0d", m, cyc - t, T_NEXT - 1); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({gnt_v[m], busy_v[m], done_v[m], tx_end_v[m], rx_data_v[m], rx_id_v[m], ss_n_v[m], mosi_v[m], sclk_v[m]}
          !== {{N{1'b0}}, 4'b0000, {B{1'b0}}, {N{1'b1}}, 1'b0, 1'(m >> 1)}) begin
        errors++; $display("FAIL reset m%0d: gnt %b busy %b done %b ss_n %b sclk %b rx %h", m, gnt_v[m], busy_v[m], done_v[m], ss_n_v[m], sclk_v[m], rx_data_v[m]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    run_one(0, 0, 8'hA5, 8'h3C, 1'b0);
  endtask

  task automatic test_modes;
    for (int m = 1; m < 4; m++) run_one(m, m % 2, 8'h81, 8'($urandom), 1'b1);
  endtask

  task automatic test_slaves;
    for (int m = 0; m < 4; m++)
      for (int r = 0; r < 3; r++)
        run_one(m, $urandom_range(0, N - 1), 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back;
    int t_prev = 0;
    int exp_id;
    int err0;
    err0 = ss_err;
    exp_id = rr_model[0];
    req_data_v[0] = (N*B)'($urandom);
    req_v[0] = '1;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(0);
      checks++;
      if (gnt_v[0] !== N'(1) << exp_id) begin errors++; $display("FAIL rr_order g%0d: got %b want %b", g, gnt_v[0], N'(1) << exp_id); end
      if (g > 0) begin
        checks++;
        if (cyc - t_prev != T_NEXT) begin errors++; $display("FAIL gnt_spacing g%0d: got %0d want %0d", g, cyc - t_prev, T_NEXT); end
      end
      t_prev = cyc;
      exp_id = (exp_id + 1) % N;
      if (g == 3) req_v[0] = '0;
    end
    rr_model[0] = exp_id;
    wait_done(0);
    wait_idle(0);
    checks++;
    if (ss_err != err0) begin errors++; $display("FAIL ss_onehot: got %0d overlaps want 0", ss_err - err0); end
  endtask

  task automatic test_drop;
    int t;
    req_data_v[0] = (N*B)'($urandom);
    req_v[0] = 2'b10;
    wait_gnt(0);
    t = cyc;
    req_v[0] = '0;
    repeat (10) @(negedge clk);
    req_v[0] = 2'b01;
    repeat (5) @(negedge clk);
    req_v[0] = '0;
    repeat (20) @(negedge clk);
    req_v[0] = 2'b10;
    wait_gnt(0);
    checks++;
    if (gnt_v[0] !== 2'b10 || cyc - t != T_NEXT) begin
      errors++; $display("FAIL dropped_req: got gnt %b at +%0d want 10 at +%0d", gnt_v[0], cyc - t, T_NEXT);
    end
    req_v[0] = '0;
    rr_model[0] = 0;
    wait_done(0);
    wait_idle(0);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int d0;
    slave_word[0][0] = 8'($urandom);
    loop_en[0] = 1'b0;
    req_data_v[0] = (N*B)'($urandom);
    req_v[0] = 2'b01;
    wait_gnt(0);
    req_v[0] = '0;
    while (e_cnt[0] < 6 && n < 200) begin @(negedge clk); n++; end
    repeat (CD - 1) @(negedge clk);
    d0 = done_cnt[0];
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ss_n_v[0], sclk_v[0], busy_v[0]} !== {2'b11, 1'b0, 1'b0}) begin
      errors++; $display("FAIL abort_state: got ss_n %b sclk %b busy %b want 11 0 0", ss_n_v[0], sclk_v[0], busy_v[0]);
    end
    repeat (3) @(negedge clk);
    req_v[0] = 2'b11;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_v[0] !== 2'b01) begin errors++; $display("FAIL gnt_after_reset: got %b want 01", gnt_v[0]); end
    req_v[0] = '0;
    repeat (60) @(negedge clk);
    checks++;
    if (done_cnt[0] != d0) begin errors++; $display("FAIL aborted_done: got %0d done pulses want 0", done_cnt[0] - d0); end
    wait_done(0);
    wait_idle(0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      req_v[m] = '0;
      req_data_v[m] = '0;
      loop_en[m] = 1'b0;
      rr_model[m] = 0;
      for (int i = 0; i < N; i++) slave_word[m][i] = '0;
    end
    test_reset;
    test_single;
    test_modes;
    test_slaves;
    test_back_to_back;
    test_drop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
